// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one countdown timer among NREQ requesters.
// A round-robin pick in IDLE grants the timer and loads that requester's value.
// The count then decrements on each 1 Hz tick and done pulses to the owner at zero.
// The run aborts silently if the owner drops its request before completion.
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  parameter int IDW  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [CW*NREQ-1:0]   param_values,
  input  logic                 tick,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [CW-1:0]        count,
  output logic [IDW-1:0]       active_id
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IDW-1:0]  active_id_q, active_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic            owner_req;
  int              idx;

  assign owner_req = req[active_id_q];

  // Round-robin search: first set request at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // Sequencer next state: grant/load in IDLE, abort > complete > tick in RUN,
  // and hold in WAIT_REL until the finished owner lets go of its request.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    count_d     = count_q;
    active_id_d = active_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          active_id_d     = win_id;
          count_d         = param_values[CW*int'(win_id) +: CW];
          rr_ptr_d        = IDW'((int'(win_id) + 1) % NREQ);
          state_d         = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          // Withdrawn request: release silently, keep count for display.
          grant_d = '0;
          state_d = IDLE;
        end else if (count_q == '0) begin
          // Completion wins over a coincident tick, so count cannot underflow.
          done_d[active_id_q] = 1'b1;
          grant_d             = '0;
          state_d             = WAIT_REL;
        end else if (tick) begin
          count_d = count_q - CW'(1);
        end
      end
      WAIT_REL: begin
        if (!owner_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any run with no done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      active_id_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      active_id_q <= active_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign count     = count_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Testbench for timer_arbiter: scenario tasks with a grant/done/count scoreboard.
module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int IDW  = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [CW*NREQ-1:0]  param_values;
  logic                tick;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                busy;
  logic [CW-1:0]       count;
  logic [IDW-1:0]      active_id;

  logic tick_en, tick_auto, tick_man;
  int   tick_ctr;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   inv_viol = 0;

  int   exp_grant[$];
  int   exp_done[$];
  int   exp_count[$];

  assign tick = (tick_auto & tick_en) | tick_man;

  timer_arbiter #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) dut (
    .clock(clock), .reset(reset), .req(req), .param_values(param_values),
    .tick(tick), .grant(grant), .done(done), .busy(busy), .count(count),
    .active_id(active_id)
  );

  always #5 clock = ~clock;

  // Free-running 1-in-10 tick source, gated by tick_en.
  initial begin
    tick_auto = 1'b0;
    tick_ctr  = 0;
    forever begin
      @(posedge clock);
      #1;
      tick_ctr  = (tick_ctr == 9) ? 0 : tick_ctr + 1;
      tick_auto = (tick_ctr == 9);
    end
  end

  // Background monitor: counts done pulses and invariant violations.
  always @(negedge clock) begin
    if (done != '0) done_cnt <= done_cnt + 1;
    if (!reset && (!$onehot0(grant) || !$onehot0(done) || ((grant & done) != '0)))
      inv_viol <= inv_viol + 1;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_param(input int i, input int v);
    param_values[CW*i +: CW] = CW'(v);
  endtask

  task automatic test_reset();
    int id;
    reset = 1'b1;
    req   = 4'b1111;
    cyc(); cyc();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b want=0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (active_id !== 2'd0) begin failures++; $display("FAIL reset_active_id got=%0d want=0", active_id); end
    reset = 1'b0;
    exp_grant.push_back(0);
    cyc();
    id = exp_grant.pop_front();
    checks++; if (grant !== NREQ'(1 << id)) begin failures++; $display("FAIL reset_first_grant got=%b want=%b", grant, NREQ'(1 << id)); end
    checks++; if (active_id !== IDW'(id)) begin failures++; $display("FAIL reset_first_id got=%0d want=%0d", active_id, id); end
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL reset_first_load got=%0d want=5", count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_first_busy got=%b want=1", busy); end
    req = '0;
    cyc(); cyc();
  endtask

  task automatic test_basic_countdown();
    int last, n, e, id;
    tick_en = 1'b1;
    req = 4'b0010;
    exp_done.push_back(1);
    exp_count.push_back(2); exp_count.push_back(1); exp_count.push_back(0);
    cyc();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL basic_grant got=%b want=0010", grant); end
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL basic_load got=%0d want=3", count); end
    last = int'(count);
    n = 0;
    while (done == '0 && n < 100) begin
      cyc();
      n++;
      if (int'(count) != last && exp_count.size() > 0) begin
        e = exp_count.pop_front();
        checks++; if (int'(count) !== e) begin failures++; $display("FAIL basic_count_seq got=%0d want=%0d", count, e); end
        last = int'(count);
      end
    end
    checks++; if (done == '0) begin failures++; $display("FAIL basic_done_timeout got=%b want=0010", done); end
    if (done != '0) begin
      id = exp_done.pop_front();
      checks++; if (done !== NREQ'(1 << id)) begin failures++; $display("FAIL basic_done got=%b want=%b", done, NREQ'(1 << id)); end
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL basic_grant_drop got=%b want=0000", grant); end
      checks++; if (exp_count.size() != 0) begin failures++; $display("FAIL basic_count_missing got=%0d want=0", exp_count.size()); end
    end
    req = '0;
    cyc();
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL basic_done_width got=%b want=0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b want=0", busy); end
    tick_en = 1'b0;
    exp_count.delete();
    exp_done.delete();
  endtask

  task automatic test_zero_value();
    int id;
    req = 4'b0100;
    exp_done.push_back(2);
    cyc();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL zero_grant got=%b want=0100", grant); end
    cyc();
    id = exp_done.pop_front();
    checks++; if (done !== NREQ'(1 << id)) begin failures++; $display("FAIL zero_done got=%b want=%b", done, NREQ'(1 << id)); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL zero_grant_drop got=%b want=0000", grant); end
    req = '0;
    cyc();
  endtask

  task automatic test_round_robin();
    int n, id;
    set_param(0, 1);
    tick_en = 1'b1;
    exp_grant.push_back(0); exp_grant.push_back(2); exp_grant.push_back(0);
    exp_grant.push_back(2); exp_grant.push_back(3);
    req = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (grant == '0 && n < 50) begin cyc(); n++; end
      id = exp_grant.pop_front();
      checks++; if (grant !== NREQ'(1 << id)) begin failures++; $display("FAIL rr_grant_%0d got=%b want=%b", k, grant, NREQ'(1 << id)); end
      if (k == 3) req[3] = 1'b1;
      if (k == 4) break;
      n = 0;
      while (done == '0 && n < 50) begin cyc(); n++; end
      checks++; if (done !== NREQ'(1 << id)) begin failures++; $display("FAIL rr_done_%0d got=%b want=%b", k, done, NREQ'(1 << id)); end
      req[id] = 1'b0;
      cyc();
      if (k < 3) req[id] = 1'b1;
    end
    req = '0;
    cyc(); cyc();
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL rr_idle got=%b/%b want=0/0000", busy, grant); end
    tick_en = 1'b0;
    exp_grant.delete();
  endtask

  task automatic test_abort();
    int d0, id;
    set_param(0, 4);
    req = 4'b0001;
    cyc();
    checks++; if (grant !== 4'b0001 || count !== 4'd4) begin failures++; $display("FAIL abort_grant got=%b/%0d want=0001/4", grant, count); end
    tick_man = 1'b1;
    cyc(); cyc();
    tick_man = 1'b0;
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL abort_count got=%0d want=2", count); end
    d0 = done_cnt;
    req = 4'b1000;
    exp_grant.push_back(3);
    cyc();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL abort_grant_drop got=%b want=0000", grant); end
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL abort_count_hold got=%0d want=2", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b want=0", busy); end
    cyc();
    id = exp_grant.pop_front();
    checks++; if (grant !== NREQ'(1 << id) || active_id !== IDW'(id)) begin failures++; $display("FAIL abort_pending_grant got=%b/%0d want=%b/%0d", grant, active_id, NREQ'(1 << id), id); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL abort_no_done got=%0d want=%0d", done_cnt, d0); end
    req = '0;
    cyc(); cyc();
  endtask

  task automatic test_collision_and_reset();
    int d0;
    set_param(1, 1);
    req = 4'b0010;
    cyc();
    checks++; if (grant !== 4'b0010 || count !== 4'd1) begin failures++; $display("FAIL coll_grant got=%b/%0d want=0010/1", grant, count); end
    d0 = done_cnt;
    tick_man = 1'b1;
    cyc();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL coll_count_zero got=%0d want=0", count); end
    cyc();
    tick_man = 1'b0;
    checks++; if (done !== 4'b0010 || count !== 4'd0) begin failures++; $display("FAIL coll_done got=%b/%0d want=0010/0", done, count); end
    cyc();
    checks++; if (done !== 4'b0000 || count !== 4'd0) begin failures++; $display("FAIL coll_after got=%b/%0d want=0000/0", done, count); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL coll_single_done got=%0d want=1", done_cnt - d0); end
    req = '0;
    cyc();
    set_param(0, 4);
    req = 4'b0001;
    cyc();
    tick_man = 1'b1;
    cyc();
    tick_man = 1'b0;
    checks++; if (grant !== 4'b0001 || count !== 4'd3) begin failures++; $display("FAIL rst_run got=%b/%0d want=0001/3", grant, count); end
    reset = 1'b1;
    req = '0;
    cyc();
    checks++; if (grant !== 4'b0000 || done !== 4'b0000 || count !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_midrun got=%b/%b/%0d/%b want=0000/0000/0/0", grant, done, count, busy); end
    d0 = done_cnt;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (done_cnt !== d0 || grant !== 4'b0000) begin failures++; $display("FAIL rst_no_done got=%0d/%b want=%0d/0000", done_cnt, grant, d0); end
  endtask

  task automatic test_invariants();
    checks++; if (inv_viol !== 0) begin failures++; $display("FAIL invariants got=%0d want=0", inv_viol); end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    tick_en = 1'b0;
    tick_man = 1'b0;
    param_values = '0;
    set_param(0, 5); set_param(1, 3); set_param(2, 0); set_param(3, 2);
    test_reset();
    test_basic_countdown();
    test_zero_value();
    test_round_robin();
    test_abort();
    test_collision_and_reset();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single countdown timer resource among up to NREQ requesters (arming delay, driver-door delay, passenger-door delay, alarm-on duration).
- Sits between the time-parameter bank and the requesting control logic.
- Grants the timer to one requester at a time, loads that requester's parameter value, and counts down on the 1 Hz enable.
- Reports completion to the owner, or aborts silently if the owner withdraws its request.

Parameters:
- NREQ, 4, number of requesters (2..4).
- CW, 4, counter/parameter value width in bits.
- IDW, 2, width of active_id, ceil(log2(NREQ)).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; held high until the done pulse, or dropped to abort.
- param_values  in  CW*NREQ  requester i's countdown value at bits [CW*i +: CW].
- tick  in  1  one-cycle 1 Hz enable strobe (one_hz_enable).
- grant  out  NREQ  one-hot owner of the timer; all zero when no owner.
- done  out  NREQ  one-cycle completion pulse to the owner.
- busy  out  1  high in RUN and WAIT_REL.
- count  out  CW  live remaining count, for display.
- active_id  out  IDW  index of the current or last owner.

Behaviour:
- Clocking and reset: all state registered on the rising edge of clock; reset is synchronous and active-high. Reset values: grant=0, done=0, busy=0, count=0, active_id=0, rr_ptr=0, state=IDLE. Reset mid-countdown aborts immediately with no done pulse.

- State IDLE:
  - If any req bit is high, pick the winner by round-robin: the first set bit searching upward from rr_ptr, wrapping at NREQ.
  - At the next edge: grant[w]=1, active_id=w, count=param_values[w], rr_ptr=(w+1) mod NREQ, state=RUN.
  - Grant latency is one cycle from the req high sample.
  - param_values is sampled only at this load; later changes are ignored until the next grant.

- State RUN, priority order per cycle:
  1. req[active_id]==0: abort. Next edge grant=0, state=IDLE, done not asserted, count holds.
  2. count==0: complete. Next edge done[active_id]=1 for exactly one cycle, grant=0, state=WAIT_REL. A tick in the same cycle is ignored.
  3. tick==1: count=count-1.
  - Requests from other requesters in RUN are held pending and never preempt.

- Completion timing: a loaded value of 0 produces done on the second cycle after grant. A value V completes at the edge after the cycle in which the V-th tick drives count to 0.

- State WAIT_REL:
  - Wait until req[active_id]==0, then state=IDLE at the next edge.
  - This prevents an immediate re-grant of the same requester.
  - Other requests stay pending.

- Boundaries:
  - count never underflows; there is no wrap.
  - req bits with index >= NREQ do not exist.
  - With a single persistent requester, the arbiter still returns to IDLE only after that requester releases.
  - Simultaneous new requests in IDLE are resolved purely by rr_ptr.

- Invariants:
  - grant is one-hot or zero.
  - done is one-hot or zero.
  - done and grant are never high in the same cycle.

Test Plan:
- Reset/idle: assert reset 2 cycles with req=4'b1111 -> all outputs 0. Release -> grant=4'b0001 one cycle later, active_id=0.
- Basic countdown: req[1]=1, param_values[1]=3, tick every 10 cycles -> count goes 3,2,1,0; done=4'b0010 for one cycle after count reaches 0; grant drops in the same edge.
- Zero value: param_values[2]=0, req[2]=1 -> grant on cycle 1, done[2] on cycle 2, no tick required.
- Round-robin fairness: req=4'b0101 held, each requester releasing and re-raising after done -> grant order 0,2,0,2. A request from 3 raised mid-run is granted after the current owner releases, ahead of 0 if rr_ptr points past 2.
- Abort: req[0] countdown at count=2, drop req[0] -> grant=0 next edge, no done pulse, state IDLE; a pending req[3] is granted the edge after that.
- Reset mid-run and tick collision: a tick in the same cycle as count==0 leaves count at 0 with a single done. Reset asserted in RUN -> grant=0, done=0, count=0, and no done pulse after release.
